// File: rtl/keypad_pkg.sv
// Shared types, constants and the row/column to key-code lookup for the keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} scan_state_t;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_result_t;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for asynchronous inputs; resets to all-ones (inactive for active-low lines).
module key_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg <= '1;
      sync_reg <= '1;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner with frame-based debounce and one strobe per press.
// Build option: define KEYPAD_STAR_HASH_EN to emit * as 4'hA and # as 4'hB; otherwise both are ignored.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_CNT);
`ifdef KEYPAD_STAR_HASH_EN
  localparam logic [11:0] HIT_MASK = 12'hFFF;
`else
  localparam logic [11:0] HIT_MASK = 12'h5FF;
`endif

  logic [NUM_COLS-1:0] col_sync;
  logic [DIV_W-1:0]    div_reg;
  logic [1:0]          row_reg;
  logic [8:0]          hits_reg;
  logic                row_last;
  logic                frame_end;
  logic [11:0]         frame_hits;
  logic [3:0]          hit_count;
  logic [3:0]          hit_code;
  frame_result_t       result;

  scan_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       cand_reg, cand_next;
  logic [3:0]       key_reg, key_next;
  logic             valid_reg, valid_next;

  key_sync #(.WIDTH(NUM_COLS)) u_col_sync (
    .clk   (clk),
    .reset (reset),
    .d     (col_n),
    .q     (col_sync)
  );

  assign row_last  = (div_reg == DIV_LAST);
  assign frame_end = row_last && (row_reg == 2'd3);

  // Rows 0-2 are latched at the end of their periods; row 3 is read live at frame end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg  <= '0;
      row_reg  <= 2'd0;
      hits_reg <= '0;
    end else if (row_last) begin
      div_reg <= '0;
      row_reg <= row_reg + 2'd1;
      case (row_reg)
        2'd0:    hits_reg[2:0] <= ~col_sync;
        2'd1:    hits_reg[5:3] <= ~col_sync;
        2'd2:    hits_reg[8:6] <= ~col_sync;
        default: ;
      endcase
    end else begin
      div_reg <= div_reg + DIV_W'(1);
    end
  end

  assign row_n      = ~(4'b0001 << row_reg);
  assign frame_hits = {~col_sync, hits_reg} & HIT_MASK;

  always_comb begin
    hit_count = '0;
    hit_code  = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (frame_hits[r*NUM_COLS+c]) begin
          hit_count = hit_count + 4'd1;
          hit_code  = key_code(2'(r), 2'(c));
        end
      end
    end
    if (hit_count == 4'd0)      result = NONE;
    else if (hit_count == 4'd1) result = SINGLE;
    else                        result = MULTI;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      cand_reg  <= '0;
      key_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cand_reg  <= cand_next;
      key_reg   <= key_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cand_next  = cand_reg;
    key_next   = key_reg;
    valid_next = 1'b0;
    if (frame_end) begin
      case (state_reg)
        IDLE: begin
          if (result == SINGLE) begin
            cand_next = hit_code;
            cnt_next  = CNT_W'(1);
            if (DEBOUNCE_CNT == 1) begin
              key_next   = hit_code;
              valid_next = 1'b1;
              state_next = PRESSED;
            end else begin
              state_next = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (result == SINGLE && hit_code == cand_reg) begin
            if (cnt_reg + CNT_W'(1) == CNT_TARGET) begin
              key_next   = cand_reg;
              valid_next = 1'b1;
              state_next = PRESSED;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end else begin
            state_next = IDLE;
          end
        end
        PRESSED: begin
          if (result == NONE) begin
            cnt_next   = CNT_W'(1);
            state_next = (DEBOUNCE_CNT == 1) ? IDLE : RELEASE;
          end
        end
        RELEASE: begin
          if (result == NONE) begin
            if (cnt_reg + CNT_W'(1) == CNT_TARGET) state_next = IDLE;
            else cnt_next = cnt_reg + CNT_W'(1);
          end else begin
            state_next = PRESSED;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign key       = key_reg;
  assign key_valid = valid_reg;
  assign key_held  = (state_reg == PRESSED) || (state_reg == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomised and directed bench for keypad_scanner against a frame-level press/release model.
module tb_keypad_scanner;

  localparam int SD    = 4;
  localparam int DC    = 3;
  localparam int FRAME = 4 * SD;

  localparam logic [11:0] K1    = 12'h001;
  localparam logic [11:0] K2    = 12'h002;
  localparam logic [11:0] K5    = 12'h010;
  localparam logic [11:0] K8    = 12'h080;
  localparam logic [11:0] KSTAR = 12'h200;
  localparam logic [11:0] K0    = 12'h400;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;
  logic [11:0] keys = '0;

  int checks = 0;
  int failures = 0;
  int dut_strobes = 0;
  int model_strobes = 0;

  // Expected outputs, updated once per frame by the model
  int         phase = 0;
  int         exp_row = 0;
  logic       exp_valid = 1'b0;
  logic [3:0] exp_key = 4'd0;
  logic       exp_held = 1'b0;
  bit         held = 1'b0;
  int         run = 0;
  int         none_run = 0;
  logic [3:0] run_key = 4'd0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
    .clk       (clk),
    .reset     (reset),
    .col_n     (col_n),
    .row_n     (row_n),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // Physical keypad: a pressed key shorts its column to the driven-low row
  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (row_n[r] == 1'b0 && keys[r*3+c]) col_n[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [3:0] pos_code(input int idx);
    int c;
    c = idx % 3;
    if (idx < 9) return 4'(idx + 1);
    if (c == 0) return 4'hA;
    if (c == 1) return 4'h0;
    return 4'hB;
  endfunction

  function automatic logic [11:0] visible(input logic [11:0] k);
`ifdef KEYPAD_STAR_HASH_EN
    return k;
`else
    return k & ~12'hA00;
`endif
  endfunction

  task automatic model_reset();
    phase = 0; exp_row = 0; exp_valid = 1'b0; exp_key = 4'd0; exp_held = 1'b0;
    held = 1'b0; run = 0; none_run = 0; run_key = 4'd0;
  endtask

  // One frame of key set -> decide strobe / held from run lengths of identical frames
  task automatic model_frame();
    logic [11:0] v;
    int n;
    logic [3:0] code;
    v = visible(keys);
    n = $countones(v);
    code = 4'd0;
    for (int i = 0; i < 12; i++) if (v[i]) code = pos_code(i);
    if (!held) begin
      if (run > 0) begin
        if (n == 1 && code == run_key) run++;
        else run = 0;
      end else if (n == 1) begin
        run = 1;
        run_key = code;
      end
      if (run == DC) begin
        exp_valid = 1'b1;
        exp_key = run_key;
        held = 1'b1;
        run = 0;
        none_run = 0;
        model_strobes++;
      end
    end else begin
      if (n == 0) begin
        none_run++;
        if (none_run == DC) begin
          held = 1'b0;
          none_run = 0;
        end
      end else begin
        none_run = 0;
      end
    end
    exp_held = held;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      exp_valid = 1'b0;
      phase++;
      if (phase == FRAME) begin
        phase = 0;
        model_frame();
      end
      exp_row = (phase / SD) % 4;
    end
  endtask

  task automatic run_frame(input logic [11:0] k);
    #1 keys = k;
    run_cycles(FRAME);
  endtask

  task automatic apply_reset();
    #2 reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [3:0] er;
    er = 4'b1111;
    er[exp_row] = 1'b0;
    check("key_valid", 32'(key_valid), 32'(exp_valid));
    check("key", 32'(key), 32'(exp_key));
    check("key_held", 32'(key_held), 32'(exp_held));
    check("row_n", 32'(row_n), 32'(er));
    check("row_onehot", $countones(~row_n), 1);
    if (key_valid === 1'b1) begin
      dut_strobes++;
      $display("strobe key=%0d time=%0t", key, $time);
    end
  end

  initial begin
    int s;
    int m;
    int len;
    int mode;
    logic [11:0] k;

    apply_reset();
    settle();
    check("reset_key", 32'(key), 0);
    check("reset_row_n", 32'(row_n), 32'hE);

    // Clean press of 5, then release
    s = dut_strobes; m = model_strobes;
    repeat (6) run_frame(K5);
    repeat (4) run_frame(12'h000);
    settle();
    check("s1_strobes", dut_strobes - s, 1);
    check("s1_model_strobes", model_strobes - m, 1);
    check("s1_key", 32'(key), 5);
    check("s1_held", 32'(key_held), 0);

    // Bounce in frame 3 restarts the count
    s = dut_strobes;
    run_frame(K5); run_frame(K5); run_frame(12'h000);
    run_frame(K5); run_frame(K5);
    settle();
    check("s2_no_early", dut_strobes - s, 0);
    run_frame(K5);
    repeat (4) run_frame(12'h000);
    settle();
    check("s2_strobes", dut_strobes - s, 1);
    check("s2_key", 32'(key), 5);

    // Two keys together
    s = dut_strobes;
    repeat (5) run_frame(K1 | K2);
    settle();
    check("s3_strobes", dut_strobes - s, 0);
    check("s3_held", 32'(key_held), 0);
    repeat (2) run_frame(12'h000);

    // Star key
    s = dut_strobes;
    repeat (4) run_frame(KSTAR);
    settle();
`ifdef KEYPAD_STAR_HASH_EN
    check("s4_strobes", dut_strobes - s, 1);
    check("s4_key", 32'(key), 32'hA);
`else
    check("s4_strobes", dut_strobes - s, 0);
    check("s4_held", 32'(key_held), 0);
`endif
    repeat (4) run_frame(12'h000);

    // Reset in the middle of the third matching frame of key 8
    s = dut_strobes;
    run_frame(K8); run_frame(K8);
    run_cycles(2 * SD);
    apply_reset();
    settle();
    check("s5_reset_strobes", dut_strobes - s, 0);
    check("s5_reset_key", 32'(key), 0);
    check("s5_reset_held", 32'(key_held), 0);
    check("s5_reset_row_n", 32'(row_n), 32'hE);
    repeat (3) run_frame(K8);
    settle();
    check("s5_strobes", dut_strobes - s, 1);
    check("s5_key", 32'(key), 8);
    repeat (4) run_frame(12'h000);

    // Long hold of key 0
    s = dut_strobes;
    repeat (20) run_frame(K0);
    settle();
    check("s6_strobes", dut_strobes - s, 1);
    check("s6_key", 32'(key), 0);
    check("s6_held", 32'(key_held), 1);
    repeat (4) run_frame(12'h000);

    // Random key patterns held for random frame counts
    for (int f = 0; f < 60; f += len) begin
      mode = $urandom_range(0, 3);
      len = $urandom_range(1, 5);
      case (mode)
        0:       k = 12'h000;
        3:       k = 12'(1 << $urandom_range(0, 11)) | 12'(1 << $urandom_range(0, 11));
        default: k = 12'(1 << $urandom_range(0, 11));
      endcase
      repeat (len) run_frame(k);
    end
    repeat (4) run_frame(12'h000);
    settle();
    check("rand_strobes", dut_strobes, model_strobes);
    check("rand_released", 32'(key_held), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
